// File: rtl/cmd_uart_link.sv
// Robot-side host command link: 8N1 UART receiver that assembles two-byte commands,
// plus an independent 8N1 transmitter for one-byte responses.
module cmd_uart_link #(
    parameter int unsigned BAUD_DIV     = 5208,
    parameter int unsigned BYTE_TIMEOUT = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);
    localparam int unsigned BW      = $clog2(BAUD_DIV + 1);
    localparam int unsigned TO_CLKS = BYTE_TIMEOUT * BAUD_DIV;
    localparam int unsigned TW      = $clog2(TO_CLKS + 1);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_LOAD = BW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] TO_LOAD   = TW'(TO_CLKS - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

    logic rx_meta, rxs;

    rx_state_t   rx_state, rx_state_nxt;
    logic [BW-1:0] rx_cnt, rx_cnt_nxt;
    logic [3:0]  rx_bit_cnt, rx_bit_cnt_nxt;
    logic [7:0]  rx_shift, rx_shift_nxt;
    logic        rx_start_c, rx_byte_vld_c, rx_frm_err_c;

    asm_state_t  asm_state, asm_state_nxt;
    logic [7:0]  hi_byte, hi_byte_nxt;
    logic [TW-1:0] to_cnt, to_cnt_nxt;
    logic [15:0] cmd_nxt;
    logic        cmd_rdy_nxt;

    tx_state_t   tx_state, tx_state_nxt;
    logic [BW-1:0] tx_cnt, tx_cnt_nxt;
    logic [3:0]  tx_bit_cnt, tx_bit_cnt_nxt;
    logic [9:0]  tx_shift, tx_shift_nxt;
    logic        tx_done_nxt;

    // RX byte engine: start-bit qualify at half period, then sample mid-bit
    always_comb begin
        rx_state_nxt   = rx_state;
        rx_cnt_nxt     = rx_cnt;
        rx_bit_cnt_nxt = rx_bit_cnt;
        rx_shift_nxt   = rx_shift;
        rx_start_c     = 1'b0;
        rx_byte_vld_c  = 1'b0;
        rx_frm_err_c   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rxs) begin
                    rx_start_c     = 1'b1;
                    rx_state_nxt   = RX_START;
                    rx_cnt_nxt     = HALF_LOAD;
                    rx_bit_cnt_nxt = 4'd0;
                end
            end
            RX_START: begin
                if (rx_cnt != '0) begin
                    rx_cnt_nxt = rx_cnt - BW'(1);
                end else if (!rxs) begin
                    rx_state_nxt = RX_DATA;
                    rx_cnt_nxt   = BAUD_LOAD;
                end else begin
                    rx_state_nxt = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (rx_cnt != '0) begin
                    rx_cnt_nxt = rx_cnt - BW'(1);
                end else begin
                    rx_shift_nxt = {rxs, rx_shift[7:1]};
                    rx_cnt_nxt   = BAUD_LOAD;
                    if (rx_bit_cnt == 4'd7) begin
                        rx_state_nxt   = RX_STOP;
                        rx_bit_cnt_nxt = 4'd0;
                    end else begin
                        rx_bit_cnt_nxt = rx_bit_cnt + 4'd1;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt != '0) begin
                    rx_cnt_nxt = rx_cnt - BW'(1);
                end else begin
                    rx_state_nxt  = RX_IDLE;
                    rx_byte_vld_c = rxs;
                    rx_frm_err_c  = !rxs;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // Command assembler; the inter-byte timeout only runs while the line is idle
    always_comb begin
        asm_state_nxt = asm_state;
        hi_byte_nxt   = hi_byte;
        to_cnt_nxt    = to_cnt;
        cmd_nxt       = cmd;
        cmd_rdy_nxt   = cmd_rdy;
        if (clr_cmd_rdy || (rx_start_c && asm_state == WAIT_HI)) begin
            cmd_rdy_nxt = 1'b0;
        end
        case (asm_state)
            WAIT_HI: begin
                if (rx_byte_vld_c) begin
                    hi_byte_nxt   = rx_shift;
                    asm_state_nxt = WAIT_LO;
                    to_cnt_nxt    = TO_LOAD;
                end
            end
            WAIT_LO: begin
                if (rx_byte_vld_c) begin
                    cmd_nxt       = {hi_byte, rx_shift};
                    cmd_rdy_nxt   = 1'b1;
                    asm_state_nxt = WAIT_HI;
                end else if (rx_state == RX_IDLE && !rx_start_c) begin
                    if (to_cnt == '0) begin
                        asm_state_nxt = WAIT_HI;
                    end else begin
                        to_cnt_nxt = to_cnt - TW'(1);
                    end
                end
            end
            default: asm_state_nxt = WAIT_HI;
        endcase
        if (rx_frm_err_c) begin
            asm_state_nxt = WAIT_HI;
        end
    end

    // TX engine: line is shift[0]; idle shift register is all ones
    always_comb begin
        tx_state_nxt   = tx_state;
        tx_cnt_nxt     = tx_cnt;
        tx_bit_cnt_nxt = tx_bit_cnt;
        tx_shift_nxt   = tx_shift;
        tx_done_nxt    = tx_done;
        case (tx_state)
            TX_IDLE: begin
                if (trmt) begin
                    tx_shift_nxt   = {1'b1, resp, 1'b0};
                    tx_done_nxt    = 1'b0;
                    tx_cnt_nxt     = BAUD_LOAD;
                    tx_bit_cnt_nxt = 4'd0;
                    tx_state_nxt   = TX_XMIT;
                end
            end
            TX_XMIT: begin
                if (tx_cnt != '0) begin
                    tx_cnt_nxt = tx_cnt - BW'(1);
                end else if (tx_bit_cnt == 4'd9) begin
                    tx_shift_nxt = '1;
                    tx_done_nxt  = 1'b1;
                    tx_state_nxt = TX_IDLE;
                end else begin
                    tx_shift_nxt   = {1'b1, tx_shift[9:1]};
                    tx_bit_cnt_nxt = tx_bit_cnt + 4'd1;
                    tx_cnt_nxt     = BAUD_LOAD;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit_cnt <= 4'd0;
            rx_shift   <= 8'd0;
            asm_state  <= WAIT_HI;
            hi_byte    <= 8'd0;
            to_cnt     <= '0;
            cmd        <= 16'd0;
            cmd_rdy    <= 1'b0;
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            tx_bit_cnt <= 4'd0;
            tx_shift   <= '1;
            tx_done    <= 1'b0;
        end else begin
            rx_meta    <= RX;
            rxs        <= rx_meta;
            rx_state   <= rx_state_nxt;
            rx_cnt     <= rx_cnt_nxt;
            rx_bit_cnt <= rx_bit_cnt_nxt;
            rx_shift   <= rx_shift_nxt;
            asm_state  <= asm_state_nxt;
            hi_byte    <= hi_byte_nxt;
            to_cnt     <= to_cnt_nxt;
            cmd        <= cmd_nxt;
            cmd_rdy    <= cmd_rdy_nxt;
            tx_state   <= tx_state_nxt;
            tx_cnt     <= tx_cnt_nxt;
            tx_bit_cnt <= tx_bit_cnt_nxt;
            tx_shift   <= tx_shift_nxt;
            tx_done    <= tx_done_nxt;
        end
    end

    assign TX = tx_shift[0];

endmodule
